// File: rtl/i2osp_stream.sv
// i2osp_stream: PKCS#1 I2OSP, converts an INT_W-bit integer to x_len octets streamed MSB first.
// Ports: clk, reset (sync, active-low); request side valid/in_ready/x/x_len;
// octet stream o_data/o_valid/o_ready/o_last; completion done/error (error only meaningful with done).
// Macro I2OSP_RANGE_CHECK_EN: when defined, CHECK also rejects x values that do not fit in x_len octets;
// when undefined, excess high octets are silently truncated and only an illegal x_len raises error.
module i2osp_stream #(
    parameter int INT_W = 2048,
    parameter int LEN_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] x,
    input  logic [LEN_W-1:0] x_len,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_last,
    output logic             done,
    output logic             error
);
    typedef enum logic [1:0] {IDLE, CHECK, STREAM, FIN} state_t;

    state_t             state, state_n;
    logic [INT_W-1:0]   x_reg, x_n;
    logic [LEN_W-1:0]   len_reg, len_n, idx, idx_n;
    logic               err, err_n, len_err, range_err;
    logic [7:0]         data_n;
    logic               valid_n, last_n;

    assign len_err = (len_reg == '0) || (len_reg > LEN_W'(INT_W / 8));

`ifdef I2OSP_RANGE_CHECK_EN
    // any bit at or above octet len_reg set means x does not fit
    assign range_err = |(x_reg >> {len_reg, 3'b000});
`else
    assign range_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        x_n     = x_reg;
        len_n   = len_reg;
        idx_n   = idx;
        err_n   = err;
        data_n  = o_data;
        valid_n = o_valid;
        last_n  = o_last;
        case (state)
            IDLE: if (valid) begin
                x_n     = x;
                len_n   = x_len;
                idx_n   = x_len - 1'b1;
                state_n = CHECK;
            end
            CHECK: begin
                err_n   = len_err || range_err;
                state_n = err_n ? FIN : STREAM;
                valid_n = !err_n;
                data_n  = err_n ? 8'h00 : x_reg[{idx, 3'b000} +: 8];
                last_n  = !err_n && (idx == '0);
            end
            STREAM: if (o_ready) begin
                if (idx == '0) begin
                    state_n = FIN;
                    valid_n = 1'b0;
                    last_n  = 1'b0;
                    data_n  = 8'h00;
                end else begin
                    idx_n  = idx - 1'b1;
                    data_n = x_reg[{idx_n, 3'b000} +: 8];
                    last_n = (idx_n == '0);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            x_reg    <= '0;
            len_reg  <= '0;
            idx      <= '0;
            err      <= 1'b0;
            in_ready <= 1'b1;
            o_data   <= 8'h00;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_n;
            x_reg    <= x_n;
            len_reg  <= len_n;
            idx      <= idx_n;
            err      <= err_n;
            in_ready <= (state_n == IDLE);
            o_data   <= data_n;
            o_valid  <= valid_n;
            o_last   <= last_n;
            done     <= (state_n == FIN);
            error    <= (state_n == FIN) && err_n;
        end
    end
endmodule

// File: tb/tb_i2osp_stream.sv
// tb_i2osp_stream: directed self-checking bench for i2osp_stream.
module tb_i2osp_stream;
    logic          clk = 1'b0;
    logic          reset;
    logic          valid;
    logic          in_ready;
    logic [2047:0] x;
    logic [8:0]    x_len;
    logic [7:0]    o_data;
    logic          o_valid;
    logic          o_ready;
    logic          o_last;
    logic          done;
    logic          error;

    int            n_vec = 0;
    int            n_err = 0;
    logic [7:0]    exp_b [256];
    int            exp_n;
    logic [2047:0] xv;

    i2osp_stream dut (
        .clk(clk), .reset(reset), .valid(valid), .in_ready(in_ready),
        .x(x), .x_len(x_len), .o_data(o_data), .o_valid(o_valid),
        .o_ready(o_ready), .o_last(o_last), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // stall_k: octet index held with o_ready low for stall_n cycles (-1 for none)
    task automatic run_req(input logic [2047:0] xi, input int len, input bit err_e,
                           input int stall_k, input int stall_n);
        chk("idle_in_ready", in_ready, 1);
        valid = 1'b1; x = xi; x_len = 9'(len);
        tick();
        valid = 1'b0;
        chk("check_o_valid", o_valid, 0);
        chk("check_in_ready", in_ready, 0);
        tick();
        if (err_e) begin
            chk("err_o_valid", o_valid, 0);
            chk("err_done", done, 1);
            chk("err_error", error, 1);
        end else begin
            for (int k = 0; k < exp_n; k++) begin
                chk("o_valid", o_valid, 1);
                chk("o_data", o_data, exp_b[k]);
                chk("o_last", o_last, 8'(k == exp_n - 1));
                chk("done_early", done, 0);
                if (k == stall_k) begin
                    o_ready = 1'b0;
                    for (int s = 0; s < stall_n; s++) begin
                        tick();
                        chk("stall_valid", o_valid, 1);
                        chk("stall_data", o_data, exp_b[k]);
                        chk("stall_last", o_last, 8'(k == exp_n - 1));
                    end
                    o_ready = 1'b1;
                end
                tick();
            end
            chk("fin_o_valid", o_valid, 0);
            chk("fin_done", done, 1);
            chk("fin_error", error, 0);
        end
        tick();
        chk("post_done", done, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    initial begin
        reset = 1'b0; valid = 1'b0; x = '0; x_len = '0; o_ready = 1'b1;
        repeat (2) tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_last", o_last, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        reset = 1'b1;
        tick();

        xv = '0; xv[23:0] = 24'h030201;

        exp_n = 3; exp_b[0] = 8'h03; exp_b[1] = 8'h02; exp_b[2] = 8'h01;
        run_req(xv, 3, 1'b0, -1, 0);

        exp_n = 5; exp_b[0] = 8'h00; exp_b[1] = 8'h00; exp_b[2] = 8'h03; exp_b[3] = 8'h02; exp_b[4] = 8'h01;
        run_req(xv, 5, 1'b0, -1, 0);

`ifdef I2OSP_RANGE_CHECK_EN
        run_req(xv, 2, 1'b1, -1, 0);
`else
        exp_n = 2; exp_b[0] = 8'h02; exp_b[1] = 8'h01;
        run_req(xv, 2, 1'b0, -1, 0);
`endif

        exp_n = 3; exp_b[0] = 8'h03; exp_b[1] = 8'h02; exp_b[2] = 8'h01;
        run_req(xv, 3, 1'b0, 1, 3);

        run_req(xv, 0, 1'b1, -1, 0);
        run_req(xv, 257, 1'b1, -1, 0);

        xv = '0; xv[2047] = 1'b1;
        exp_n = 256; exp_b[0] = 8'h80;
        for (int i = 1; i < 256; i++) exp_b[i] = 8'h00;
        run_req(xv, 256, 1'b0, -1, 0);

        xv = '0; xv[23:0] = 24'h030201;
        valid = 1'b1; x = xv; x_len = 9'd3;
        tick();
        valid = 1'b0;
        tick();
        chk("abort_first", o_data, 8'h03);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_o_valid", o_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", done, 0);
            chk("abort_quiet", o_valid, 0);
        end

        exp_n = 3; exp_b[0] = 8'h03; exp_b[1] = 8'h02; exp_b[2] = 8'h01;
        run_req(xv, 3, 1'b0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
